uart_bus_master: RTL and testbench
==================================

// Module: uart_bus_master
// PURPOSE
// - Bus initiator driven by PC over UART: parses command frames from UART RX bytes, issues single
//   rd/wr transactions on the CPU data bus (same rd/wr/addr/wdata/rdata protocol peripherals answer),
//   returns result bytes via UART TX. Sits beside CPU; arbitration via bus_req/bus_gnt. Debug/loader path.
// PARAMETERS
// - TIMEOUT_CYCLES  50000000  max clk cycles between bytes of one frame before frame is discarded
// - WIN_BASE        32'h40000000  lower bound of permitted address window (ADDR_WINDOW_EN only)
// - WIN_SPAN        32'h00000024  window size in bytes; allowed iff WIN_BASE <= addr < WIN_BASE+WIN_SPAN
// PORTS
// - clk       in   1   system clock
// - reset     in   1   synchronous, active-low reset
// - rx_valid  in   1   one-cycle pulse: rx_data holds a received byte
// - rx_data   in   8   received byte
// - tx_ready  in   1   UART transmitter idle, may accept tx_start
// - tx_start  out  1   one-cycle pulse: transmit tx_data
// - tx_data   out  8   byte to transmit; stable from tx_start until tx_ready returns
// - bus_req   out  1   request bus ownership
// - bus_gnt   in   1   bus granted; CPU stalled while high
// - rd        out  1   bus read strobe, one cycle
// - wr        out  1   bus write strobe, one cycle
// - addr      out  32  bus address
// - wdata     out  32  bus write data
// - rdata     in   32  bus read data, combinational, valid same cycle as rd
// - busy      out  1   high whenever state != IDLE
// BEHAVIOUR
// - Reset (reset==0 at posedge clk): state=IDLE; all outputs 0; byte counter, timer, shift regs cleared.
//   Reset mid-frame/mid-response abandons it; no further bus or TX activity.
// - Frame: cmd byte, 4 addr bytes MSB first, then (write only) 4 data bytes MSB first.
//   cmd 0x57 'W' = write, 0x52 'R' = read; any other cmd -> respond 0x3F '?', back to IDLE.
// - States: IDLE -> ADDR(4 bytes) -> [DATA(4 bytes) if W] -> REQ -> ACCESS -> RESP <-> TX_WAIT -> IDLE.
// - REQ: bus_req=1; on first cycle bus_gnt==1 go ACCESS. ACCESS (exactly 1 cycle): rd or wr=1 with addr/wdata
//   valid; read captures rdata same cycle; bus_req drops next cycle (leaving ACCESS).
// - Response: W -> single byte 0x4B 'K'; R -> 4 bytes of captured rdata, MSB first.
// - TX handshake: tx_start pulsed only in a cycle where tx_ready==1; then TX_WAIT for >=2 cycles,
//   leaving only when tx_ready==1 again; next byte or IDLE follows.
// - Timeout: timer reset on every rx_valid; counts in ADDR/DATA only. Reaching TIMEOUT_CYCLES -> IDLE,
//   partial frame discarded, no response. rx_valid in same cycle as expiry: byte accepted, timer restarts.
// - rx_valid in REQ/ACCESS/RESP/TX_WAIT is ignored (byte dropped); in IDLE it is always a cmd byte.
// - addr/wdata assembled by 8-bit left shift; hold last values in IDLE; rd/wr never both 1.
// CONFIGURATION
// - UART_BUS_ADDR_WINDOW_EN defined: after last addr byte, address outside window -> remaining data bytes
//   (W) still consumed, then respond 0x21 '!' without REQ/ACCESS (bus_req stays 0).
// - Not defined: no check; WIN_BASE/WIN_SPAN unused; every well-formed frame reaches the bus.
// TESTING
// - Frame 57 40 00 00 0C 00 00 00 A5, bus_gnt=1 -> one wr pulse, addr=0x4000000C, wdata=0x000000A5; TX 0x4B.
// - Frame 52 40 00 00 10, rdata=0x0000003C at rd -> one rd pulse; TX 00 00 00 3C in order.
// - bus_gnt held 0 for 100 cycles in REQ -> bus_req=1, rd=wr=0 throughout; access on grant cycle +1.
// - Cmd 0x41 -> TX 0x3F, no bus_req; following valid frame processed normally.
// - 57 40 00 then TIMEOUT_CYCLES idle -> IDLE, no TX; next frame 52 .. executes correctly.
// - ADDR_WINDOW_EN: 52 00 00 00 00 -> TX 0x21, bus_req never asserted; reset mid-RESP -> tx_start stays 0.

Source files
------------

// File: rtl/uart_bus_master.sv
// uart_bus_master
//   Bus initiator driven over UART. Parses command frames from received
//   bytes, performs one read or write on the CPU data bus after arbitration,
//   and sends the result back through the UART transmitter.
//
//   Frame : cmd, addr[31:24], addr[23:16], addr[15:8], addr[7:0],
//           then for writes data[31:24] .. data[7:0].
//           cmd 'W' (0x57) = write, 'R' (0x52) = read, anything else -> '?'.
//   Reply : write -> 'K'; read -> 4 bytes of read data, MSB first;
//           rejected address -> '!'.
//
//   Parameters
//     TIMEOUT_CYCLES  idle cycles between bytes of one frame before it is dropped
//     WIN_BASE        permitted address window base (window check build only)
//     WIN_SPAN        permitted address window size in bytes
//
//   Build option
//     UART_BUS_ADDR_WINDOW_EN  when defined, addresses outside
//                              [WIN_BASE, WIN_BASE+WIN_SPAN) are answered
//                              with '!' and never reach the bus.
//
//   Ports
//     clk, reset         clock, synchronous active-low reset
//     rx_valid, rx_data  received byte strobe and value
//     tx_ready           transmitter idle
//     tx_start, tx_data  transmit strobe and byte (held until tx_ready returns)
//     bus_req, bus_gnt   bus ownership request / grant
//     rd, wr             one-cycle bus strobes
//     addr, wdata        bus address / write data
//     rdata              bus read data, valid in the rd cycle
//     busy               high whenever not idle
module uart_bus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter logic [31:0] WIN_BASE       = 32'h4000_0000,
  parameter logic [31:0] WIN_SPAN       = 32'h0000_0024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        rd,
  output logic        wr,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_UNK = 8'h3F;
  localparam logic [7:0] RSP_ERR = 8'h21;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_REQ,
    S_ACCESS,
    S_RESP,
    S_TX_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    byte_cnt, byte_cnt_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          is_write, is_write_nxt;
  logic          addr_bad, addr_bad_nxt;
  logic [31:0]   addr_nxt, wdata_nxt;
  logic [31:0]   resp_sr, resp_nxt;
  logic [2:0]    resp_cnt, resp_cnt_nxt;
  logic          wait_cnt, wait_cnt_nxt;

  // Address as it will be once the current byte is shifted in.
  logic [31:0] asm_addr;
  logic        in_win;

  assign asm_addr = {addr[23:0], rx_data};

`ifdef UART_BUS_ADDR_WINDOW_EN
  // Offset compare avoids overflow of WIN_BASE + WIN_SPAN.
  assign in_win = (asm_addr >= WIN_BASE) && ((asm_addr - WIN_BASE) < WIN_SPAN);
`else
  logic win_unused;
  assign win_unused = ^{WIN_BASE, WIN_SPAN};
  assign in_win     = 1'b1;
`endif

  // Byte in transmission is always the top of the response shift register,
  // so it stays stable until the next shift.
  assign tx_data = resp_sr[31:24];
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      timer    <= '0;
      is_write <= 1'b0;
      addr_bad <= 1'b0;
      addr     <= '0;
      wdata    <= '0;
      resp_sr  <= '0;
      resp_cnt <= '0;
      wait_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      timer    <= timer_nxt;
      is_write <= is_write_nxt;
      addr_bad <= addr_bad_nxt;
      addr     <= addr_nxt;
      wdata    <= wdata_nxt;
      resp_sr  <= resp_nxt;
      resp_cnt <= resp_cnt_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    timer_nxt    = timer;
    is_write_nxt = is_write;
    addr_bad_nxt = addr_bad;
    addr_nxt     = addr;
    wdata_nxt    = wdata;
    resp_nxt     = resp_sr;
    resp_cnt_nxt = resp_cnt;
    wait_cnt_nxt = wait_cnt;
    tx_start     = 1'b0;
    bus_req      = 1'b0;
    rd           = 1'b0;
    wr           = 1'b0;

    case (state)
      S_IDLE: begin
        if (rx_valid) begin
          timer_nxt    = '0;
          byte_cnt_nxt = '0;
          if (rx_data == CMD_W || rx_data == CMD_R) begin
            is_write_nxt = (rx_data == CMD_W);
            addr_bad_nxt = 1'b0;
            state_nxt    = S_ADDR;
          end else begin
            resp_nxt     = {RSP_UNK, 24'h0};
            resp_cnt_nxt = 3'd1;
            state_nxt    = S_RESP;
          end
        end
      end

      S_ADDR, S_DATA: begin
        if (rx_valid) begin
          // A byte arriving in the expiry cycle still counts.
          timer_nxt    = '0;
          byte_cnt_nxt = byte_cnt + 2'd1;
          if (state == S_ADDR) begin
            addr_nxt = asm_addr;
            if (byte_cnt == 2'd3) begin
              addr_bad_nxt = !in_win;
              if (is_write) begin
                state_nxt = S_DATA;
              end else if (!in_win) begin
                resp_nxt     = {RSP_ERR, 24'h0};
                resp_cnt_nxt = 3'd1;
                state_nxt    = S_RESP;
              end else begin
                state_nxt = S_REQ;
              end
            end
          end else begin
            wdata_nxt = {wdata[23:0], rx_data};
            if (byte_cnt == 2'd3) begin
              if (addr_bad) begin
                resp_nxt     = {RSP_ERR, 24'h0};
                resp_cnt_nxt = 3'd1;
                state_nxt    = S_RESP;
              end else begin
                state_nxt = S_REQ;
              end
            end
          end
        end else if (timer == TIMER_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end

      S_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          state_nxt = S_ACCESS;
        end
      end

      S_ACCESS: begin
        bus_req = 1'b1;
        rd      = !is_write;
        wr      = is_write;
        if (is_write) begin
          resp_nxt     = {RSP_OK, 24'h0};
          resp_cnt_nxt = 3'd1;
        end else begin
          resp_nxt     = rdata;
          resp_cnt_nxt = 3'd4;
        end
        state_nxt = S_RESP;
      end

      S_RESP: begin
        if (tx_ready) begin
          tx_start     = 1'b1;
          wait_cnt_nxt = 1'b0;
          state_nxt    = S_TX_WAIT;
        end
      end

      S_TX_WAIT: begin
        // First cycle here is always spent waiting; tx_ready may still
        // show the pre-start idle level.
        wait_cnt_nxt = 1'b1;
        if (wait_cnt && tx_ready) begin
          if (resp_cnt == 3'd1) begin
            resp_cnt_nxt = '0;
            state_nxt    = S_IDLE;
          end else begin
            resp_cnt_nxt = resp_cnt - 3'd1;
            resp_nxt     = {resp_sr[23:0], 8'h00};
            state_nxt    = S_RESP;
          end
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_bus_master.sv
module tb_uart_bus_master;

  localparam int unsigned TMO = 64;
  localparam logic [31:0] WB  = 32'h4000_0000;
  localparam logic [31:0] WS  = 32'h0000_0024;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        bus_req;
  logic        bus_gnt;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;

  always #5 clk = ~clk;

  uart_bus_master #(
    .TIMEOUT_CYCLES(TMO),
    .WIN_BASE(WB),
    .WIN_SPAN(WS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .tx_ready(tx_ready),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .bus_req(bus_req),
    .bus_gnt(bus_gnt),
    .rd(rd),
    .wr(wr),
    .addr(addr),
    .wdata(wdata),
    .rdata(rdata),
    .busy(busy)
  );

  // Peripheral read data: one fixed location, everything else a scramble of the address.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h4000_0010) return 32'h0000_003C;
    return {a[7:0], a[31:24] ^ 8'h5A, ~a[15:8], a[23:16]};
  endfunction

  assign rdata = rd ? slave_data(addr) : 32'hDEAD_BEEF;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } bus_ev_t;

  logic [7:0] tx_log[$];
  bus_ev_t    bus_log[$];
  int         proto_err   = 0;
  int         req_wait    = 0;
  int         last_wait   = 0;
  int         gnt_delay   = 0;
  int         tx_hold_min = 0;
  int         tx_hold_max = 6;

  // Bus observer plus arbiter. Grant rises gnt_delay cycles after the request
  // is first seen; the access must come exactly one cycle after a granted request.
  initial begin
    int  gcnt;
    bit  gnt_seen;
    bit  after_access;
    bus_gnt      = 1'b0;
    gcnt         = 0;
    gnt_seen     = 1'b0;
    after_access = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bus_gnt      = 1'b0;
        gcnt         = 0;
        gnt_seen     = 1'b0;
        after_access = 1'b0;
        req_wait     = 0;
      end else begin
        if (rd && wr) proto_err++;
        if (rd || wr) begin
          if (!bus_req || !gnt_seen) proto_err++;
          bus_log.push_back('{w: wr, a: addr, d: wdata});
          last_wait    = req_wait;
          req_wait     = 0;
          after_access = 1'b1;
        end else begin
          if (gnt_seen) proto_err++;
          if (after_access && bus_req) proto_err++;
          after_access = 1'b0;
          if (bus_req) req_wait++;
        end
        if (bus_req && !rd && !wr && !bus_gnt) begin
          if (gcnt >= gnt_delay) bus_gnt = 1'b1;
          else gcnt++;
        end else if (!bus_req) begin
          bus_gnt = 1'b0;
          gcnt    = 0;
        end
        gnt_seen = bus_req && bus_gnt && !rd && !wr;
      end
    end
  end

  // UART transmitter model: logs each started byte, goes not-ready for a
  // random time and requires tx_data to hold meanwhile.
  initial begin
    int         hold;
    logic [7:0] held;
    tx_ready = 1'b1;
    hold     = 0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        tx_ready = 1'b1;
        hold     = 0;
      end else if (tx_start) begin
        if (!tx_ready) proto_err++;
        tx_log.push_back(tx_data);
        held     = tx_data;
        tx_ready = 1'b0;
        hold     = $urandom_range(tx_hold_max, tx_hold_min);
      end else if (!tx_ready) begin
        if (tx_data !== held) proto_err++;
        if (hold == 0) tx_ready = 1'b1;
        else hold--;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  function automatic bit addr_allowed(input logic [31:0] a);
`ifdef UART_BUS_ADDR_WINDOW_EN
    return ({1'b0, a} >= {1'b0, WB}) && ({1'b0, a} < ({1'b0, WB} + {1'b0, WS}));
`else
    return 1'b1;
`endif
  endfunction

  // Sends one frame and compares the transmitted bytes and bus traffic with
  // what the frame rules demand. gap_fixed < 0 selects random short gaps.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] a,
                           input logic [31:0] d, input int gdelay, input int gap_fixed);
    logic [7:0]  frame[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] v;
    bit          exp_bus;
    int          n;
    frame   = {cmd};
    exp_tx  = {};
    exp_bus = 1'b0;
    if (cmd == 8'h57 || cmd == 8'h52) begin
      for (int i = 3; i >= 0; i--) frame.push_back(a[8*i +: 8]);
      if (cmd == 8'h57)
        for (int i = 3; i >= 0; i--) frame.push_back(d[8*i +: 8]);
      if (!addr_allowed(a)) begin
        exp_tx.push_back(8'h21);
      end else if (cmd == 8'h57) begin
        exp_tx.push_back(8'h4B);
        exp_bus = 1'b1;
      end else begin
        v = slave_data(a);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(v[8*i +: 8]);
        exp_bus = 1'b1;
      end
    end else begin
      exp_tx.push_back(8'h3F);
    end

    tx_log.delete();
    bus_log.delete();
    gnt_delay = gdelay;
    foreach (frame[i]) send_byte(frame[i], (gap_fixed < 0) ? $urandom_range(3, 0) : gap_fixed);
    wait_idle(tag);

    check({tag, ".ntx"}, 32'(tx_log.size()), 32'(exp_tx.size()));
    n = (tx_log.size() < exp_tx.size()) ? tx_log.size() : exp_tx.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.tx%0d", tag, i), 32'(tx_log[i]), 32'(exp_tx[i]));
    check({tag, ".nbus"}, 32'(bus_log.size()), exp_bus ? 32'd1 : 32'd0);
    if (exp_bus && bus_log.size() == 1) begin
      check({tag, ".wr"}, 32'(bus_log[0].w), (cmd == 8'h57) ? 32'd1 : 32'd0);
      check({tag, ".addr"}, bus_log[0].a, a);
      if (cmd == 8'h57) check({tag, ".wdata"}, bus_log[0].d, d);
      check({tag, ".reqcyc"}, 32'(last_wait), 32'(gdelay + 1));
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".ctl"}, 32'({tx_start, bus_req, rd, wr, busy}), 32'd0);
    check({tag, ".txd"}, 32'(tx_data), 32'd0);
    check({tag, ".addr"}, addr, 32'd0);
    check({tag, ".wdata"}, wdata, 32'd0);
  endtask

  initial begin
    logic [7:0]  c;
    logic [31:0] a;
    int          sel;
    int          k;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(negedge clk);
    check_quiet("rst");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_frame("wr_basic", 8'h57, 32'h4000_000C, 32'h0000_00A5, 0, -1);
    run_frame("rd_basic", 8'h52, 32'h4000_0010, 32'h0, 3, -1);
    run_frame("gnt_hold", 8'h52, 32'h4000_0004, 32'h0, 100, -1);
    run_frame("bad_cmd", 8'h41, 32'h0, 32'h0, 0, -1);
    run_frame("after_bad", 8'h57, 32'h4000_0020, 32'hCAFE_F00D, 1, -1);
    run_frame("rd_zero", 8'h52, 32'h0000_0000, 32'h0, 0, -1);
    run_frame("wr_far", 8'h57, 32'h1234_5678, 32'h9ABC_DEF0, 2, -1);

    // Gaps of exactly the timeout length are still within one frame.
    run_frame("gap_edge", 8'h57, 32'h4000_0008, 32'h0102_0304, 0, TMO - 1);

    // Partial frame abandoned after the timeout, no response.
    tx_log.delete();
    bus_log.delete();
    send_byte(8'h57, 0);
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    repeat (TMO - 1) @(negedge clk);
    check("tmo.pre", 32'(busy), 32'd1);
    @(negedge clk);
    check("tmo.post", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("tmo.ntx", 32'(tx_log.size()), 32'd0);
    check("tmo.nbus", 32'(bus_log.size()), 32'd0);
    run_frame("after_tmo", 8'h52, 32'h4000_0010, 32'h0, 0, -1);

    for (int f = 0; f < 24; f++) begin
      sel = $urandom_range(9, 0);
      if (sel < 4) c = 8'h57;
      else if (sel < 8) c = 8'h52;
      else begin
        c = 8'($urandom_range(255, 0));
        if (c == 8'h57 || c == 8'h52) c = 8'h00;
      end
      a = ($urandom_range(1, 0) == 1) ? WB + $urandom_range(35, 0) : $urandom();
      run_frame($sformatf("rnd%0d", f), c, a, $urandom(), $urandom_range(5, 0), -1);
    end

    // Reset while a read response is going out: no further bytes.
    tx_hold_min = 12;
    tx_hold_max = 16;
    tx_log.delete();
    bus_log.delete();
    gnt_delay = 0;
    send_byte(8'h52, 0);
    send_byte(8'h40, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h14, 0);
    k = 0;
    while (tx_log.size() == 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rstmid.first", 32'(tx_log.size()), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("rstmid");
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check("rstmid.ntx", 32'(tx_log.size()), 32'd1);
    check("rstmid.busy", 32'(busy), 32'd0);
    tx_hold_min = 0;
    tx_hold_max = 6;
    run_frame("after_rst", 8'h57, 32'h4000_0000, 32'h5A5A_A5A5, 0, -1);

    check("protocol", 32'(proto_err), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
